// File: rtl/instruction_encoder.sv
// Purpose     : packs decoded RV32 fields plus a 32-bit immediate into an instruction word; LI expands to LUI+ADDI.
// Latency     : one registered stage; a request accepted at edge N is presented from edge N onward.
// Backpressure: valid/ready both sides; o_ready = !second_beat_owed && (!o_valid || i_ready), no steady-state bubble.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     request handshake (accepted when both high)
//   i_format              0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_immediate   request fields
//   o_valid / i_ready     output beat handshake
//   o_instruction         encoded instruction word
//   o_last                final beat of the current request
//   o_range_error         immediate not encodable in this beat (low bits still packed)
//   o_error_count         saturating count of range-error beats taken downstream

module instruction_encoder #(
    parameter int XLEN      = 32,   // only 32 is supported
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_format,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [XLEN-1:0]      i_immediate,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_instruction,
    output logic                 o_last,
    output logic                 o_range_error,
    output logic [ERR_CNT_W-1:0] o_error_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;   // output register empty
    localparam logic [1:0] ST_HOLD   = 2'd1;   // beat presented, nothing further owed
    localparam logic [1:0] ST_SECOND = 2'd2;   // first LI beat presented, ADDI still owed

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_OP_IMM = 7'h13;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [31:0] pend_instr;    // ADDI rd,rd,lo waiting behind the LUI beat

    logic [31:0] imm;
    assign imm = i_immediate[31:0];

    // ------------------------------------------------------------------
    // Immediate range checks: "upper bits all equal" is the two's
    // complement test for "fits in the narrower signed field".
    // ------------------------------------------------------------------
    logic fits_12;      // imm[31:11] uniform -> 12-bit signed (I, S, LI short form)
    logic fits_13;      // imm[31:12] uniform -> 13-bit signed (B)
    logic fits_21;      // imm[31:20] uniform -> 21-bit signed (J)

    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    // LI upper part: (imm + 0x800)[31:12]. Adding 0x800 only carries into
    // bit 12 when imm[11] is set, so a 20-bit increment is sufficient and
    // compensates for the sign extension of the low 12 bits in ADDI.
    logic [19:0] li_hi;
    assign li_hi = imm[31:12] + {19'd0, imm[11]};

    // ------------------------------------------------------------------
    // Combinational encoder for the incoming request
    // ------------------------------------------------------------------
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        enc_two_beat;
    logic [31:0] enc_second;

    always_comb begin
        enc_instr    = 32'd0;
        enc_err      = 1'b0;
        enc_two_beat = 1'b0;
        enc_second   = 32'd0;

        case (i_format)
            FMT_R: begin
                enc_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end

            FMT_I: begin
                enc_instr = {imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_err   = ~fits_12;
            end

            FMT_S: begin
                enc_instr = {imm[11:5], i_rs2, i_rs1, i_funct3, imm[4:0], i_opcode};
                enc_err   = ~fits_12;
            end

            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded.
                enc_instr = {imm[12], imm[10:5], i_rs2, i_rs1, i_funct3,
                             imm[4:1], imm[11], i_opcode};
                enc_err   = ~fits_13 | imm[0];
            end

            FMT_U: begin
                enc_instr = {imm[31:12], i_rd, i_opcode};
                enc_err   = |imm[11:0];
            end

            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], i_rd, i_opcode};
                enc_err   = ~fits_21 | imm[0];
            end

            FMT_LI: begin
                // LI is always representable, so it never flags a range error.
                if (fits_12) begin
                    // ADDI rd, x0, lo
                    enc_instr = {imm[11:0], 5'd0, 3'b000, i_rd, OP_OP_IMM};
                end else if (imm[11:0] == 12'd0) begin
                    // Low part is zero: LUI alone is exact (li_hi == imm[31:12]).
                    enc_instr = {li_hi, i_rd, OP_LUI};
                end else begin
                    // LUI rd, hi ; ADDI rd, rd, lo
                    enc_instr    = {li_hi, i_rd, OP_LUI};
                    enc_two_beat = 1'b1;
                    enc_second   = {imm[11:0], i_rd, 3'b000, i_rd, OP_OP_IMM};
                end
            end

            default: begin
                // Reserved format: emit an all-zero word and flag it.
                enc_instr = 32'd0;
                enc_err   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;   // request taken this cycle
    logic take;     // output beat consumed this cycle

    assign o_ready = (state != ST_SECOND) && (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;
    assign take    = o_valid && i_ready;

    // ------------------------------------------------------------------
    // Output register and FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            o_valid       <= 1'b0;
            o_instruction <= 32'd0;
            o_last        <= 1'b0;
            o_range_error <= 1'b0;
            pend_instr    <= 32'd0;
        end else begin
            if (accept) begin
                // Covers both an idle load and a same-cycle replace of a
                // consumed beat; o_ready already excludes the SECOND state.
                o_valid       <= 1'b1;
                o_instruction <= enc_instr;
                o_last        <= ~enc_two_beat;
                o_range_error <= enc_err;
                pend_instr    <= enc_second;
                state         <= enc_two_beat ? ST_SECOND : ST_HOLD;
            end else if (take) begin
                if (state == ST_SECOND) begin
                    // LUI beat gone: present the owed ADDI as the last beat.
                    o_valid       <= 1'b1;
                    o_instruction <= pend_instr;
                    o_last        <= 1'b1;
                    o_range_error <= 1'b0;
                    state         <= ST_HOLD;
                end else begin
                    // Data fields keep their last value; only valid drops.
                    o_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating range-error counter, counted at downstream acceptance
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_error_count <= '0;
        end else if (take && o_range_error && !(&o_error_count)) begin
            o_error_count <= o_error_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
